regfile_mp_bypass: RTL and testbench

- Parametrised multi-read-port register file for the datapath.
- Generalises the fixed 16-to-1, 32-bit register read mux to DEPTH registers of WIDTH bits, with NUM_RD independent read ports.
- Read outputs are registered (1-cycle latency) with same-cycle write bypass.
- Top register (index DEPTH-1) is the program counter, with its own dedicated write port and a continuously visible output.

---
 rtl/regfile_mp_bypass.sv | 106 ++++++++++
 tb/tb_regfile_mp_bypass.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_bypass.sv
// regfile_mp_bypass: DEPTH x WIDTH register file with NUM_RD registered read
// ports and same-cycle write bypass. The top register (DEPTH-1) is the
// program counter, with its own write port and a direct output pc_q.
// Optional macro REGFILE_PC_INC_EN adds pc_inc / PC_STEP auto-increment.
module regfile_mp_bypass #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int NUM_RD = 3
`ifdef REGFILE_PC_INC_EN
  ,
  parameter int PC_STEP = 4
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [WIDTH-1:0]        wd,
  input  logic                    pc_we,
  input  logic [WIDTH-1:0]        pc_d,
`ifdef REGFILE_PC_INC_EN
  input  logic                    pc_inc,
`endif
  input  logic                    re,
  input  logic [NUM_RD*AW-1:0]    ra,
  output logic [NUM_RD*WIDTH-1:0] rd,
  output logic [WIDTH-1:0]        pc_q
);

  localparam logic [AW-1:0] PC_IDX = AW'(DEPTH - 1);

  logic [WIDTH-1:0]        regs [DEPTH];
  logic [WIDTH-1:0]        pc_next;
  logic [NUM_RD*WIDTH-1:0] rd_next;
  logic [NUM_RD*WIDTH-1:0] rd_p1;

  // Addresses at or above DEPTH map to nothing: reads give 0, writes drop.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // Next PC value with write priority pc_we > general write > increment.
  always_comb begin
    pc_next = regs[DEPTH-1];
    if (pc_we) begin
      pc_next = pc_d;
    end else if (we && (wa == PC_IDX)) begin
      pc_next = wd;
    end
`ifdef REGFILE_PC_INC_EN
    else if (pc_inc) begin
      pc_next = regs[DEPTH-1] + WIDTH'(PC_STEP);
    end
`endif
  end

  // Per-port bypassed read value; the PC slot reuses pc_next so reads see
  // exactly what the register is about to hold.
  always_comb begin
    logic [AW-1:0] a;
    a       = '0;
    rd_next = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = ra[i*AW +: AW];
      if (a == PC_IDX) begin
        rd_next[i*WIDTH +: WIDTH] = pc_next;
      end else if (!in_range(a)) begin
        rd_next[i*WIDTH +: WIDTH] = '0;
      end else if (we && (wa == a)) begin
        rd_next[i*WIDTH +: WIDTH] = wd;
      end else begin
        rd_next[i*WIDTH +: WIDTH] = regs[a];
      end
    end
  end

  // Register storage: general writes below the PC slot, PC slot via pc_next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (we && (wa == AW'(k))) begin
          regs[k] <= wd;
        end
      end
      regs[DEPTH-1] <= pc_next;
    end
  end

  // ---- read stage p0 -> p1: registered read data, held while re is low ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p1 <= '0;
    end else if (re) begin
      rd_p1 <= rd_next;
    end
  end

  assign rd   = rd_p1;
  assign pc_q = regs[DEPTH-1];

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Directed testbench for regfile_mp_bypass: a 16-entry instance for the main
// function and a 12-entry instance for out-of-range addressing.
module tb_regfile_mp_bypass;

  logic        clk = 1'b0;
  logic        reset;

  // 16-entry instance
  logic        we, pc_we, re;
  logic [3:0]  wa;
  logic [31:0] wd, pc_d, pc_q;
  logic [11:0] ra;
  logic [95:0] rd;
`ifdef REGFILE_PC_INC_EN
  logic        pc_inc;
`endif

  // 12-entry instance
  logic        we2, pc_we2, re2;
  logic [3:0]  wa2;
  logic [31:0] wd2, pc_d2, pc_q2;
  logic [11:0] ra2;
  logic [95:0] rd2;
`ifdef REGFILE_PC_INC_EN
  logic        pc_inc2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp_bypass #(.WIDTH(32), .DEPTH(16), .AW(4), .NUM_RD(3)) u_dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .pc_we(pc_we), .pc_d(pc_d),
`ifdef REGFILE_PC_INC_EN
    .pc_inc(pc_inc),
`endif
    .re(re), .ra(ra), .rd(rd), .pc_q(pc_q)
  );

  regfile_mp_bypass #(.WIDTH(32), .DEPTH(12), .AW(4), .NUM_RD(3)) u_dut12 (
    .clk(clk), .reset(reset), .we(we2), .wa(wa2), .wd(wd2),
    .pc_we(pc_we2), .pc_d(pc_d2),
`ifdef REGFILE_PC_INC_EN
    .pc_inc(pc_inc2),
`endif
    .re(re2), .ra(ra2), .rd(rd2), .pc_q(pc_q2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    we = 0; wa = 0; wd = 0; pc_we = 0; pc_d = 0; re = 0; ra = 0;
    we2 = 0; wa2 = 0; wd2 = 0; pc_we2 = 0; pc_d2 = 0; re2 = 0; ra2 = 0;
`ifdef REGFILE_PC_INC_EN
    pc_inc = 0; pc_inc2 = 0;
`endif
    #1;
    chk("reset_rd0", rd[31:0], 32'h0);
    chk("reset_pcq", pc_q, 32'h0);
    #11;
    reset = 1'b0;

    // 1. reset clears a written register and the outputs immediately
    we = 1; wa = 4'd5; wd = 32'hDEADBEEF;
    tick();
    we = 0; re = 1; ra = {4'd5, 4'd5, 4'd5};
    tick();
    chk("pre_reset_rd0", rd[31:0], 32'hDEADBEEF);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_rd0", rd[31:0], 32'h0);
    chk("async_reset_rd2", rd[95:64], 32'h0);
    chk("async_reset_pcq", pc_q, 32'h0);
    #1 reset = 1'b0;
    tick();
    chk("post_reset_reg5", rd[31:0], 32'h0);

    // 2. fill all registers, then read {3,12,11}
    re = 0;
    for (int k = 0; k < 16; k++) begin
      we = 1; wa = 4'(k); wd = 32'h1000_0000 + 32'(k);
      tick();
    end
    we = 0; re = 1; ra = {4'd3, 4'd12, 4'd11};
    tick();
    chk("fill_rd0_r11", rd[31:0],  32'h1000000B);
    chk("fill_rd1_r12", rd[63:32], 32'h1000000C);
    chk("fill_rd2_r3",  rd[95:64], 32'h10000003);
    chk("fill_pcq",     pc_q,      32'h1000000F);

    // 3. bypass: write and read reg 7 in the same cycle on two ports
    we = 1; wa = 4'd7; wd = 32'h11111111; re = 0;
    tick();
    wd = 32'h22222222; re = 1; ra = {4'd0, 4'd7, 4'd7};
    tick();
    chk("bypass_rd0", rd[31:0],  32'h22222222);
    chk("bypass_rd1", rd[63:32], 32'h22222222);
    chk("bypass_rd2_r0", rd[95:64], 32'h10000000);
    we = 0;
    tick();
    chk("stored_r7", rd[31:0], 32'h22222222);

    // 4. PC conflict: pc_we beats a general write to reg 15
    we = 1; wa = 4'd15; wd = 32'hAAAA0000; pc_we = 1; pc_d = 32'h100;
    ra = {4'd0, 4'd15, 4'd0};
    tick();
    chk("pcconf_rd1", rd[63:32], 32'h100);
    chk("pcconf_pcq", pc_q, 32'h100);
    // different indices in one cycle both land
    we = 1; wa = 4'd2; wd = 32'h33; pc_we = 1; pc_d = 32'h200;
    ra = {4'd0, 4'd15, 4'd2};
    tick();
    chk("dual_rd0_r2", rd[31:0], 32'h33);
    chk("dual_rd1_pc", rd[63:32], 32'h200);
    // general write to PC slot without pc_we
    we = 1; wa = 4'd15; wd = 32'h1234; pc_we = 0;
    tick();
    chk("genwr_pc_pcq", pc_q, 32'h1234);
    we = 0;

    // 5. DEPTH=12: out-of-range reads and writes, read hold
    we2 = 1; wa2 = 4'd13; wd2 = 32'h99; re2 = 1; ra2 = {4'd13, 4'd13, 4'd13};
    tick();
    chk("oor_bypass_rd0", rd2[31:0], 32'h0);
    we2 = 0; ra2 = {4'd9, 4'd5, 4'd1};
    tick();
    chk("oor_alias_r1", rd2[31:0],  32'h0);
    chk("oor_alias_r5", rd2[63:32], 32'h0);
    chk("oor_alias_r9", rd2[95:64], 32'h0);
    chk("oor_pcq", pc_q2, 32'h0);
    ra2 = {4'd13, 4'd13, 4'd13};
    tick();
    chk("oor_read13", rd2[31:0], 32'h0);
    pc_we2 = 1; pc_d2 = 32'hABC; ra2 = {4'd0, 4'd0, 4'd11};
    tick();
    pc_we2 = 0;
    chk("d12_pc_rd0", rd2[31:0], 32'hABC);
    chk("d12_pcq", pc_q2, 32'hABC);
    we2 = 1; wa2 = 4'd2; wd2 = 32'h11; ra2 = {4'd0, 4'd0, 4'd2};
    tick();
    chk("hold_pre", rd2[31:0], 32'h11);
    re2 = 0; wd2 = 32'h55;
    tick();
    chk("hold_rd0", rd2[31:0], 32'h11);
    we2 = 0; re2 = 1;
    tick();
    chk("hold_after", rd2[31:0], 32'h55);

`ifdef REGFILE_PC_INC_EN
    // 6. PC increment: wrap, then priority below explicit writes
    pc_we = 1; pc_d = 32'hFFFFFFFC; re = 0;
    tick();
    pc_we = 0; pc_inc = 1; re = 1; ra = {4'd0, 4'd0, 4'd15};
    tick();
    chk("inc_wrap_pcq", pc_q, 32'h0);
    chk("inc_wrap_rd0", rd[31:0], 32'h0);
    pc_we = 1; pc_d = 32'h40;
    tick();
    chk("inc_vs_pcwe", pc_q, 32'h40);
    pc_we = 0; we = 1; wa = 4'd15; wd = 32'h500;
    tick();
    chk("inc_vs_we", pc_q, 32'h500);
    we = 0;
    tick();
    chk("inc_step", pc_q, 32'h504);
    chk("inc_step_rd0", rd[31:0], 32'h504);
    pc_inc = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
